// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a parallel byte as start, data LSB-first, optional parity, stop bits
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]                r_state;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [PRESCALE_WIDTH-1:0] r_pm1;
    logic [BW-1:0]             r_bit_cnt;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_parity;
    logic                      w_last;
    logic [2:0]                w_state_nxt;
    logic [BW-1:0]             w_bit_nxt;
    logic                      w_tx_nxt;

    // next state, next bit index and the line level they imply, so tx_out can be a plain flop
    always_comb begin
        w_last      = r_edge_cnt == r_pm1;
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        case (r_state)
            IDLE:    if (data_valid) w_state_nxt = START;
            START:   if (w_last) w_state_nxt = DATA;
            DATA:    if (w_last) begin
                         if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                             w_state_nxt = r_par_en ? PARITY : STOP;
                             w_bit_nxt   = '0;
                         end else begin
                             w_bit_nxt = r_bit_cnt + 1'b1;
                         end
                     end
            PARITY:  if (w_last) w_state_nxt = STOP;
            STOP:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_tx_nxt = w_state_nxt == START  ? 1'b0 :
                   w_state_nxt == DATA   ? r_data[w_bit_nxt] :
                   w_state_nxt == PARITY ? r_parity : 1'b1;
    end

    // frame sequencing; reset forces the line high at once, aborting any frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_edge_cnt <= (r_state == IDLE || w_last) ? '0 : r_edge_cnt + 1'b1;
            tx_out     <= w_tx_nxt;
            busy       <= w_state_nxt != IDLE;
        end
    end

    // frame settings are captured only on acceptance; prescale 0 behaves as 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data   <= '0;
            r_par_en <= 1'b0;
            r_parity <= 1'b0;
            r_pm1    <= '0;
        end else if (r_state == IDLE && data_valid) begin
            r_data   <= p_data;
            r_par_en <= par_en;
            r_parity <= ^p_data ^ par_typ;
            r_pm1    <= prescale == '0 ? '0 : prescale - 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random and directed frames checked cycle by cycle against a bit-list line model
module tb_uart_tx_serializer;
    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic       tx_out;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // called at a negedge with the line idle; the frame is accepted on the next posedge
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps, input bit noise, input bit hold);
        int         p;
        int         nb;
        logic       exp_bit;
        logic       par;
        logic [7:0] rx;
        p   = ps == 0 ? 1 : int'(ps);
        nb  = 10 + (pe ? 1 : 0);
        par = (($countones(d) % 2) == 1) ^ pt;
        rx  = 8'h00;
        p_data = d; par_en = pe; par_typ = pt; prescale = ps; data_valid = 1'b1;
        @(posedge clk);
        for (int n = 0; n < nb; n++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge clk);
                if (n == 0) exp_bit = 1'b0;
                else if (n <= 8) exp_bit = d[n-1];
                else if (pe && n == 9) exp_bit = par;
                else exp_bit = 1'b1;
                check("tx", tx_out, exp_bit);
                check("busy", busy, 1);
                if (n >= 1 && n <= 8 && c == p / 2) rx[n-1] = tx_out;
                if (noise) begin
                    p_data     = 8'($urandom);
                    par_en     = 1'($urandom);
                    par_typ    = 1'($urandom);
                    prescale   = 6'($urandom);
                    data_valid = hold | 1'($urandom);
                end else begin
                    data_valid = hold;
                end
            end
        end
        @(negedge clk);
        check("rx_byte", rx, d);
        check("idle_tx", tx_out, 1);
        check("idle_busy", busy, 0);
        data_valid = hold;
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd1;
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_tx", tx_out, 1);
            check("rst_busy", busy, 0);
            p_data = 8'($urandom); data_valid = 1'($urandom); prescale = 6'($urandom);
        end
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_tx", tx_out, 1);
            check("post_rst_busy", busy, 0);
        end
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b0, 1'b0, 6'd16, 1'b0, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0);
        p_data = 8'hFF; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd4; data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("mid_busy", busy, 1);
        #1 rst = 1'b0;
        #1;
        check("abort_tx", tx_out, 1);
        check("abort_busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_tx", tx_out, 1);
            check("abort_hold_busy", busy, 0);
        end
        rst = 1'b1;
        run_frame(8'h01, 1'b0, 1'b0, 6'd3, 1'b0, 1'b0);
        run_frame(8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        run_frame(8'h00, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0);
        repeat (25) begin
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), 1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("gap_tx", tx_out, 1);
                check("gap_busy", busy, 0);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
